// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer defaults, pointer type and pointer helper functions.
package fifo_pkg;

    localparam int DEF_PTR_WIDTH   = 5;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CONV_PIPE   = 0;

    typedef logic [DEF_PTR_WIDTH-1:0] ptr_t;

    // True when more than one bit of v is set (clearing the lowest set bit leaves something).
    function automatic logic pop_gt1(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at and above it.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_ptr_sync.sv
// CDC receiver for a Gray FIFO pointer: flop synchronizer, Gray-to-binary, update pulse and modulo delta.
// Optional multi-bit-change checker is compiled in with GRAY_PTR_SYNC_ERR_CHK_EN.
module gray_ptr_sync
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH   = DEF_PTR_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CONV_PIPE   = DEF_CONV_PIPE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PTR_WIDTH-1:0] g_in,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] ptr_gray_sync,
    output logic [PTR_WIDTH-1:0] ptr_bin,
    output logic                 ptr_upd,
    output logic [PTR_WIDTH-1:0] ptr_delta,
    output logic                 err_multi_bit
);

    localparam int L = SYNC_STAGES - 1;

    logic [PTR_WIDTH-1:0] s [SYNC_STAGES];
    logic [PTR_WIDTH-1:0] conv_in;
    logic [PTR_WIDTH-1:0] next_bin;
    logic [PTR_WIDTH-1:0] prev_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) s[i] <= '0;
        end else begin
            s[0] <= g_in;
            for (int i = 1; i < SYNC_STAGES; i++) s[i] <= s[i-1];
        end
    end

    assign ptr_gray_sync = s[L];

    // next_bin is the value ptr_bin takes after the coming edge. Without the pipe it is taken
    // from the stage before the last, so prev_bin always equals conv(ptr_gray_sync) and the
    // registered pulse/delta line up with ptr_bin.
    if (CONV_PIPE != 0) begin : g_pipe
        assign conv_in = s[L];
    end else begin : g_nopipe
        assign conv_in = s[L-1];
    end

    gray2bin #(.W(PTR_WIDTH)) u_gray2bin (
        .gray (conv_in),
        .bin  (next_bin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bin  <= '0;
            ptr_upd   <= 1'b0;
            ptr_delta <= '0;
        end else begin
            prev_bin  <= next_bin;
            ptr_upd   <= (next_bin != prev_bin);
            ptr_delta <= next_bin - prev_bin;
        end
    end

    assign ptr_bin = prev_bin;

`ifdef GRAY_PTR_SYNC_ERR_CHK_EN
    logic err_set;

    assign err_set = pop_gt1(64'(s[L] ^ s[L-1]));

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_multi_bit <= 1'b0;
        else if (err_set) err_multi_bit <= 1'b1;
        else if (err_clr) err_multi_bit <= 1'b0;
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_multi_bit  = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
module tb_gray_ptr_sync;

`ifdef GRAY_PTR_SYNC_ERR_CHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] g_in = 5'b10110;
    logic [4:0] g1_in = 5'b00000;
    logic       err_clr = 1'b0;

    logic [4:0] gs0, pb0, pd0, gs1, pb1, pd1;
    logic       pu0, pu1, er0, er1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.PTR_WIDTH(5), .SYNC_STAGES(2), .CONV_PIPE(0)) dut0 (
        .clk (clk), .rst (rst), .g_in (g_in), .err_clr (err_clr),
        .ptr_gray_sync (gs0), .ptr_bin (pb0), .ptr_upd (pu0),
        .ptr_delta (pd0), .err_multi_bit (er0)
    );

    gray_ptr_sync #(.PTR_WIDTH(5), .SYNC_STAGES(3), .CONV_PIPE(1)) dut1 (
        .clk (clk), .rst (rst), .g_in (g1_in), .err_clr (err_clr),
        .ptr_gray_sync (gs1), .ptr_bin (pb1), .ptr_upd (pu1),
        .ptr_delta (pd1), .err_multi_bit (er1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    initial begin
        logic [4:0] bb_g [3];
        logic [4:0] bb_b [3];
        bb_g[0] = 5'b00011; bb_b[0] = 5'd2;
        bb_g[1] = 5'b00010; bb_b[1] = 5'd3;
        bb_g[2] = 5'b00110; bb_b[2] = 5'd4;

        // Reset held with non-zero g_in
        repeat (2) @(negedge clk);
        chk("rst_gs", gs0, 0);
        chk("rst_bin", pb0, 0);
        chk("rst_upd", pu0, 0);
        chk("rst_delta", pd0, 0);
        chk("rst_err", er0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_bin_early", pb0, 0);
        @(negedge clk);
        chk("rel_gs", gs0, 5'b10110);
        chk("rel_bin", pb0, 5'b11011);
        chk("rel_upd", pu0, 1);
        chk("rel_delta", pd0, 5'b11011);
        @(negedge clk);
        chk("rel_upd_end", pu0, 0);
        chk("rel_delta_end", pd0, 0);

        // Reset asserted between edges mid-transfer
        g_in = 5'b10010;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_gs", gs0, 0);
        chk("mid_bin", pb0, 0);
        chk("mid_upd", pu0, 0);
        chk("mid_err", er0, 0);
        @(negedge clk);
        g_in = 5'b00000;
        rst  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_rel_upd", pu0, 0);
            chk("zero_rel_bin", pb0, 0);
        end

        // Single step 0 -> 1
        g_in = 5'b00001;
        @(negedge clk);
        chk("step_upd_early", pu0, 0);
        chk("step_bin_early", pb0, 0);
        @(negedge clk);
        chk("step_bin", pb0, 1);
        chk("step_upd", pu0, 1);
        chk("step_delta", pd0, 1);
        @(negedge clk);
        chk("step_upd_end", pu0, 0);
        chk("step_delta_end", pd0, 0);
        chk("step_bin_hold", pb0, 1);

        // Back-to-back single-bit changes
        for (int i = 0; i < 5; i++) begin
            if (i < 3) g_in = bb_g[i];
            @(negedge clk);
            if (i >= 1 && i <= 3) begin
                chk("b2b_bin", pb0, bb_b[i-1]);
                chk("b2b_upd", pu0, 1);
                chk("b2b_delta", pd0, 1);
            end
        end

        // Walk up to binary 31 then wrap to 0
        for (int i = 5; i < 32; i++) begin
            g_in = 5'(i ^ (i >> 1));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("pre_wrap_bin", pb0, 31);
        chk("pre_wrap_gs", gs0, 5'b10000);
        g_in = 5'b00000;
        repeat (2) @(negedge clk);
        chk("wrap_bin", pb0, 0);
        chk("wrap_upd", pu0, 1);
        chk("wrap_delta", pd0, 1);
        chk("wrap_err", er0, 0);
        @(negedge clk);

        // Multi-bit jump 00000 -> 00011
        g_in = 5'b00011;
        repeat (2) @(negedge clk);
        chk("jump_bin", pb0, 2);
        chk("jump_delta", pd0, 2);
        chk("jump_err", er0, ERR_ON);
        g_in = 5'b00010;
        repeat (2) @(negedge clk);
        chk("sticky_delta", pd0, 1);
        chk("sticky_err", er0, ERR_ON);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", er0, 0);

        // Set and clear on the same edge: set wins
        g_in = 5'b00101;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("setclr_bin", pb0, 6);
        chk("setclr_delta", pd0, 3);
        chk("setclr_err", er0, ERR_ON);
        @(negedge clk);
        chk("setclr_err_hold", er0, ERR_ON);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("final_clr_err", er0, 0);

        // Latency with SYNC_STAGES=3, CONV_PIPE=1
        g1_in = 5'b00001;
        repeat (3) @(negedge clk);
        chk("lat_gs", gs1, 1);
        chk("lat_bin_early", pb1, 0);
        chk("lat_upd_early", pu1, 0);
        @(negedge clk);
        chk("lat_bin", pb1, 1);
        chk("lat_upd", pu1, 1);
        chk("lat_delta", pd1, 1);
        @(negedge clk);
        chk("lat_upd_end", pu1, 0);
        chk("lat_err", er1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Clock-domain-crossing receiver for a Gray-coded FIFO pointer. Captures a Gray pointer driven from the opposite clock domain through a configurable-depth flop synchronizer, then converts it to binary with an optional output pipeline register. Produces an update strobe and a modulo pointer delta for the local full/empty logic. It sits in each side of the asynchronous FIFO: the write side instantiates it for the read pointer, the read side for the write pointer.

## Interface
- PTR_WIDTH, 5, pointer width including the wrap bit (depth 16 plus 1); minimum 2
- SYNC_STAGES, 2, number of synchronizer flops; minimum 2
- CONV_PIPE, 0, 1 inserts a register after the Gray-to-binary conversion
- clk  in  1  local-domain clock; the block's only clock
- rst  in  1  reset; asynchronous and active-high, clears all state immediately
- g_in  in  PTR_WIDTH  Gray pointer from the foreign domain; asynchronous to clk
- err_clr  in  1  clears sticky err_multi_bit
- ptr_gray_sync  out  PTR_WIDTH  last synchronizer stage
- ptr_bin  out  PTR_WIDTH  binary equivalent of the synchronized pointer
- ptr_upd  out  1  one-cycle pulse when ptr_bin changes
- ptr_delta  out  PTR_WIDTH  (ptr_bin_new − ptr_bin_prev) mod 2^PTR_WIDTH, valid when ptr_upd=1
- err_multi_bit  out  1  sticky flag: synchronized Gray value changed by more than one bit

## Operation
- Synchronizer: shift chain s[0..SYNC_STAGES-1]; s[0] samples g_in each clk edge; ptr_gray_sync = s[SYNC_STAGES-1].
- Conversion: b[i] = XOR of gray bits PTR_WIDTH-1 down to i.
- CONV_PIPE=0: ptr_bin is the combinational conversion of ptr_gray_sync. CONV_PIPE=1: ptr_bin is registered.
- A register prev_bin holds the binary value from the previous cycle. When ptr_bin ≠ prev_bin, ptr_upd=1 and ptr_delta = ptr_bin − prev_bin, truncated to PTR_WIDTH. Otherwise ptr_upd=0 and ptr_delta=0.
- ptr_upd and ptr_delta are registered outputs, aligned to the first cycle that ptr_bin shows the new value.
- Wrap-around is handled by the modulo arithmetic: prev 31 → new 0 gives delta 1 when PTR_WIDTH=5.
- Error check (when compiled in): popcount(s[last] XOR s[last-1]) > 1 sets err_multi_bit.
  - err_multi_bit stays set until err_clr is sampled high.
  - If a set and err_clr occur in the same cycle, the set wins.
- Reset:
  - Every output, synchronizer stage and prev_bin is 0.
  - After reset release with a non-zero g_in, the value propagates normally and produces a ptr_upd pulse with delta equal to that value.
  - Reset asserted mid-transfer drops all state to 0 in the same instant; no pulse is generated on reset assertion.

## Timing
- g_in change to ptr_gray_sync: SYNC_STAGES edges.
- ptr_bin: SYNC_STAGES edges when CONV_PIPE=0, SYNC_STAGES+1 when CONV_PIPE=1.
- ptr_upd/ptr_delta are driven from registers and asserted in the same cycle as the new ptr_bin.
  - CONV_PIPE=0: compare and outputs are registered off the pre-sync stage, so the pulse aligns with ptr_bin.
- Back-to-back g_in changes on consecutive edges yield consecutive ptr_upd pulses, each with delta 1.
- No input handshake: g_in must change by at most one bit per foreign-clock edge. Throughput is limited only by clk.

## Configuration
- GRAY_PTR_SYNC_ERR_CHK_EN defined: popcount comparator, sticky err_multi_bit and err_clr are present.
- Not defined: err_multi_bit is tied 0, err_clr is ignored, and no comparator logic is generated.

## Structure
- Shared package fifo_pkg holds:
  - default PTR_WIDTH, SYNC_STAGES, CONV_PIPE constants;
  - ptr_t typedef (logic [PTR_WIDTH-1:0]);
  - popcount-greater-than-one function.
- One sub-module, gray2bin: parametrised combinational Gray-to-binary converter, instantiated once.
- Synchronizer, pipeline, delta and error logic live in gray_ptr_sync.

## Test plan
- Reset: hold rst=1 with g_in=10110 -> all outputs 0. Release -> after 2 edges ptr_gray_sync=10110, ptr_bin=11011, ptr_upd=1, ptr_delta=11011.
- Single step, CONV_PIPE=0, SYNC_STAGES=2: g_in 00000→00001 at edge 0 -> at edge 2 ptr_bin=00001, ptr_upd one cycle, ptr_delta=1.
- Wrap: settle g_in=10000 (bin 31), then g_in=00000 -> ptr_bin=0, ptr_delta=1, err_multi_bit=0.
- Multi-bit jump, macro on: g_in 00000→00011 -> ptr_delta=2 and err_multi_bit=1. err_multi_bit holds across later valid steps, clears one edge after err_clr=1. Set and clear on the same edge -> flag stays 1.
- Latency sweep: CONV_PIPE=1, SYNC_STAGES=3 -> ptr_bin and ptr_upd appear 4 edges after the g_in change.
- Reset mid-stream: assert rst between edges while s[0]≠0 -> outputs 0 immediately, no ptr_upd pulse. After release with g_in=0 -> no pulse.
